vga_controller: RTL
===================

Name: vga_controller

Overview:
- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Drives the 14-bit read address of the 128x96 image memory (mem, 12288 words, 1-bit R/G/B, registered read with 1-clk latency). Each image pixel is upscaled 5x5 to fill the screen.
- Registers the returned colour, gates it with the active-video window and aligns it with hsync/vsync at the board pins.

Parameters:
CLK_DIV, 4, system clocks per pixel (25 MHz pixel tick)
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, hsync pulse width, pixels
H_BP, 48, horizontal back porch, pixels (line total 800)
V_VISIBLE, 480, active lines
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vsync pulse width, lines
V_BP, 33, vertical back porch, lines (frame total 525)
SCALE, 5, screen pixels per image pixel, both axes
IMG_W, 128, image width
IMG_H, 96, image height
ADDR_W, 14, memory address width

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high
red_in  in  1  red bit from mem, valid 1 clk after address
green_in  in  1  green bit from mem
blue_in  in  1  blue bit from mem
address  out  ADDR_W  image memory read address
vga_red  out  1  red to DAC/pin
vga_green  out  1  green to pin
vga_blue  out  1  blue to pin
vga_hsync  out  1  horizontal sync, active-low
vga_vsync  out  1  vertical sync, active-low

Behaviour:
- Reset (async, any time, including mid-frame):
  - all counters = 0; address = 0
  - vga_red/green/blue = 0
  - vga_hsync = vga_vsync = 1
  - After release, the frame restarts at (h=0, v=0). No partial-frame recovery.
- Pixel tick:
  - Divider counts 0..CLK_DIV-1; tick = 1 for one clk when divider = CLK_DIV-1.
  - All state below advances only on tick.
- Counters:
  - h_cnt 0..799 wraps to 0.
  - On each h_cnt wrap, v_cnt advances 0..524 and wraps to 0.
- Address generation (no divider/multiplier):
  - sub_x 0..4 increments per visible pixel; at 4 it returns to 0 and img_x increments (0..127).
  - sub_y / img_y likewise per visible line.
  - line_base += IMG_W whenever sub_y wraps; line_base = 0 at frame start.
  - address register updates on the same edge as the counters, to the value for the new (h,v):
    - inside the visible area: line_base + img_x
    - outside it: 0
  - Range is always 0..12287. address = 12287 exactly at (639..635, 479..475) region end.
- Output pipeline:
  - On the tick following (h,v), register:
    - colour = {red_in, green_in, blue_in} if (h,v) was visible, else 0
    - hsync = 0 iff 656 <= h <= 751
    - vsync = 0 iff 490 <= v <= 491
  - All five outputs therefore lag the counters by exactly one pixel and are mutually aligned.
  - Memory data has CLK_DIV-1 spare clocks of margin.
- Colour is forced 0 during any blanking, regardless of memory contents.

Decomposition:
- Package vga_pkg holds the timing constants: visible/porch/sync widths, line/frame totals, sync start/end positions, image size, SCALE.
- Sub-module vga_timing contains the divider, h/v counters, tick, visible flag and raw sync.
- vga_controller contains the scaled address generator and the output alignment registers.

Test Plan:
- Reset asserted mid-line, with async release away from the clk edge:
  - All outputs immediately show address=0, rgb=0, hsync=vsync=1.
  - The first tick occurs 4 clks after release.
- Line 0 sweep:
  - address sequence is 0 (x5), 1 (x5), … 127 (x5) over h=0..639, then 0 during h=640..799.
  - Every 4th clk yields one address step.
- Row scaling:
  - Lines 0–4 start at address 0, lines 5–9 at 128.
  - Line 479 starts at 12160 and ends at 12287.
  - v=480..524 keep address = 0.
- Sync timing, checked at the outputs:
  - vga_hsync low for exactly 96 ticks, beginning one tick after h=656.
  - vga_vsync low for exactly 2 lines, beginning one tick after v=490.
  - Frame period 420000 ticks.
- Colour gating:
  - Hold red_in=green_in=blue_in=1 constantly.
  - rgb=111 only for 640 ticks per visible line, delayed by one tick.
  - rgb=000 throughout blanking and vertical blank.
- Memory latency alignment:
  - Model mem returning bit0 of address as red_in one clk later.
  - vga_red toggles every 5 ticks, in phase with address changes delayed by one tick.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Default 640x480@60 Hz timing, image geometry and shared types
//               for the VGA controller slice.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Pixel clock divider: 100 MHz system clock -> 25 MHz pixel tick
  localparam int c_clk_div      = 4;

  // Horizontal timing, in pixels
  localparam int c_h_visible    = 640;
  localparam int c_h_fp         = 16;
  localparam int c_h_sync       = 96;
  localparam int c_h_bp         = 48;
  localparam int c_h_total      = c_h_visible + c_h_fp + c_h_sync + c_h_bp;
  localparam int c_h_sync_start = c_h_visible + c_h_fp;
  localparam int c_h_sync_end   = c_h_sync_start + c_h_sync - 1;

  // Vertical timing, in lines
  localparam int c_v_visible    = 480;
  localparam int c_v_fp         = 10;
  localparam int c_v_sync       = 2;
  localparam int c_v_bp         = 33;
  localparam int c_v_total      = c_v_visible + c_v_fp + c_v_sync + c_v_bp;
  localparam int c_v_sync_start = c_v_visible + c_v_fp;
  localparam int c_v_sync_end   = c_v_sync_start + c_v_sync - 1;

  // Source image and upscale factor
  localparam int c_scale        = 5;
  localparam int c_img_w        = 128;
  localparam int c_img_h        = 96;
  localparam int c_addr_w       = 14;

  // One-bit-per-channel colour as returned by the image memory
  typedef struct packed {
    logic red;
    logic green;
    logic blue;
  } rgb_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Pixel-tick divider, horizontal/vertical counters, visible
//               window and raw (unregistered) active-low sync for the
//               current counter position.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = c_clk_div,
  parameter int H_VISIBLE = c_h_visible,
  parameter int H_FP      = c_h_fp,
  parameter int H_SYNC    = c_h_sync,
  parameter int H_BP      = c_h_bp,
  parameter int V_VISIBLE = c_v_visible,
  parameter int V_FP      = c_v_fp,
  parameter int V_SYNC    = c_v_sync,
  parameter int V_BP      = c_v_bp,
  parameter int HW        = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP),
  parameter int VW        = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP)
)(
  input  logic          clk,
  input  logic          i_rst,
  output logic          o_tick,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_line_end,
  output logic          o_frame_end,
  output logic          o_h_active,
  output logic          o_v_active,
  output logic          o_visible,
  output logic          o_next_visible,
  output logic          o_hsync_n,
  output logic          o_vsync_n
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] c_div_last  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] c_h_last    = HW'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [VW-1:0] c_v_last    = VW'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [HW-1:0] c_h_vis     = HW'(H_VISIBLE);
  localparam logic [VW-1:0] c_v_vis     = VW'(V_VISIBLE);
  localparam logic [HW-1:0] c_h_vis_end = HW'(H_VISIBLE - 1);
  localparam logic [VW-1:0] c_v_vis_end = VW'(V_VISIBLE - 1);
  localparam logic [HW-1:0] c_hs_start  = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] c_hs_end    = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] c_vs_start  = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] c_vs_end    = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  logic w_tick;
  logic w_line_end;
  logic w_frame_end;
  logic w_h_active;
  logic w_v_active;
  logic w_h_next_act;
  logic w_v_next_act;

  assign w_tick      = (r_div == c_div_last);
  assign w_line_end  = (r_h_cnt == c_h_last);
  assign w_frame_end = w_line_end && (r_v_cnt == c_v_last);
  assign w_h_active  = (r_h_cnt < c_h_vis);
  assign w_v_active  = (r_v_cnt < c_v_vis);

  // Visibility of the position the counters move to on the next tick
  assign w_h_next_act = w_line_end || (r_h_cnt < c_h_vis_end);
  assign w_v_next_act = w_frame_end ? 1'b1 :
                        w_line_end  ? (r_v_cnt < c_v_vis_end) : w_v_active;

  // Free-running pixel divider; tick marks its last count
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // Horizontal and vertical position, advancing once per pixel tick
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_tick) begin
      if (w_line_end) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  assign o_tick         = w_tick;
  assign o_h_cnt        = r_h_cnt;
  assign o_v_cnt        = r_v_cnt;
  assign o_line_end     = w_line_end;
  assign o_frame_end    = w_frame_end;
  assign o_h_active     = w_h_active;
  assign o_v_active     = w_v_active;
  assign o_visible      = w_h_active && w_v_active;
  assign o_next_visible = w_h_next_act && w_v_next_act;
  assign o_hsync_n      = !((r_h_cnt >= c_hs_start) && (r_h_cnt <= c_hs_end));
  assign o_vsync_n      = !((r_v_cnt >= c_vs_start) && (r_v_cnt <= c_vs_end));

endmodule
`default_nettype wire

// File: rtl/vga_controller.sv
`default_nettype none
// ============================================================================
// Module      : vga_controller
// Description : 640x480@60 Hz VGA controller. Generates the image-memory read
//               address for a SCALE x SCALE upscaled image using counters only
//               (no multiply/divide), and registers gated colour plus sync so
//               all pins change together one pixel after the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_controller
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = c_clk_div,
  parameter int H_VISIBLE = c_h_visible,
  parameter int H_FP      = c_h_fp,
  parameter int H_SYNC    = c_h_sync,
  parameter int H_BP      = c_h_bp,
  parameter int V_VISIBLE = c_v_visible,
  parameter int V_FP      = c_v_fp,
  parameter int V_SYNC    = c_v_sync,
  parameter int V_BP      = c_v_bp,
  parameter int SCALE     = c_scale,
  parameter int IMG_W     = c_img_w,
  parameter int ADDR_W    = c_addr_w
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              red_in,
  input  logic              green_in,
  input  logic              blue_in,
  output logic [ADDR_W-1:0] address,
  output logic              vga_red,
  output logic              vga_green,
  output logic              vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync
);

  localparam int HW = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [SW-1:0]     c_sub_last = SW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] c_line_inc = ADDR_W'(IMG_W);

  logic          w_tick;
  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_line_end;
  logic          w_frame_end;
  logic          w_h_active;
  logic          w_v_active;
  logic          w_visible;
  logic          w_next_visible;
  logic          w_hsync_n;
  logic          w_vsync_n;

  vga_timing #(
    .CLK_DIV   (CLK_DIV),
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .HW        (HW),
    .VW        (VW)
  ) u_timing (
    .clk            (clk),
    .i_rst          (reset),
    .o_tick         (w_tick),
    .o_h_cnt        (w_h_cnt),
    .o_v_cnt        (w_v_cnt),
    .o_line_end     (w_line_end),
    .o_frame_end    (w_frame_end),
    .o_h_active     (w_h_active),
    .o_v_active     (w_v_active),
    .o_visible      (w_visible),
    .o_next_visible (w_next_visible),
    .o_hsync_n      (w_hsync_n),
    .o_vsync_n      (w_vsync_n)
  );

  // Scaled-coordinate state for the current counter position. line_base is
  // img_y * IMG_W kept as a running sum so no multiplier is needed.
  logic [SW-1:0]     r_sub_x;
  logic [XW-1:0]     r_img_x;
  logic [SW-1:0]     r_sub_y;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_address;

  logic [SW-1:0]     w_sub_x_nxt;
  logic [XW-1:0]     w_img_x_nxt;
  logic [SW-1:0]     w_sub_y_nxt;
  logic [ADDR_W-1:0] w_line_base_nxt;
  logic [ADDR_W-1:0] w_address_nxt;

  rgb_t r_rgb;
  logic r_hsync;
  logic r_vsync;

  // Next scaled coordinates and the address for the position entered on tick
  always_comb begin
    w_sub_x_nxt     = r_sub_x;
    w_img_x_nxt     = r_img_x;
    w_sub_y_nxt     = r_sub_y;
    w_line_base_nxt = r_line_base;

    if (w_line_end) begin
      w_sub_x_nxt = '0;
      w_img_x_nxt = '0;
    end else if (w_h_active) begin
      if (r_sub_x == c_sub_last) begin
        w_sub_x_nxt = '0;
        w_img_x_nxt = r_img_x + 1'b1;
      end else begin
        w_sub_x_nxt = r_sub_x + 1'b1;
      end
    end

    if (w_frame_end) begin
      w_sub_y_nxt     = '0;
      w_line_base_nxt = '0;
    end else if (w_line_end && w_v_active) begin
      if (r_sub_y == c_sub_last) begin
        w_sub_y_nxt     = '0;
        w_line_base_nxt = r_line_base + c_line_inc;
      end else begin
        w_sub_y_nxt = r_sub_y + 1'b1;
      end
    end

    w_address_nxt = w_next_visible ? (w_line_base_nxt + ADDR_W'(w_img_x_nxt)) : '0;
  end

  // Address generator state, updated on the same tick as the counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sub_x     <= '0;
      r_img_x     <= '0;
      r_sub_y     <= '0;
      r_line_base <= '0;
      r_address   <= '0;
    end else if (w_tick) begin
      r_sub_x     <= w_sub_x_nxt;
      r_img_x     <= w_img_x_nxt;
      r_sub_y     <= w_sub_y_nxt;
      r_line_base <= w_line_base_nxt;
      r_address   <= w_address_nxt;
    end
  end

  // Output alignment: colour and sync of the pixel just finished, together.
  // Memory data is valid one clock after the address, well before this tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_tick) begin
      r_rgb   <= w_visible ? rgb_t'({red_in, green_in, blue_in}) : '0;
      r_hsync <= w_hsync_n;
      r_vsync <= w_vsync_n;
    end
  end

  assign address   = r_address;
  assign vga_red   = r_rgb.red;
  assign vga_green = r_rgb.green;
  assign vga_blue  = r_rgb.blue;
  assign vga_hsync = r_hsync;
  assign vga_vsync = r_vsync;

endmodule
`default_nettype wire
